// File: rtl/l2_amo_seq_pkg.sv
// Shared widths, AMO opcodes, size codes and sequencer state encodings
// for the L2 atomic-memory-operation path.
package l2_amo_seq_pkg;

    localparam int PHY_ADDR_WIDTH      = 40;
    localparam int L2_DATA_DATA_WIDTH  = 128;
    localparam int MSG_DATA_SIZE_WIDTH = 3;
    localparam int L2_AMO_ALU_OP_WIDTH = 4;

    localparam logic [L2_AMO_ALU_OP_WIDTH-1:0] L2_AMO_ALU_NOP  = 4'd0;
    localparam logic [L2_AMO_ALU_OP_WIDTH-1:0] L2_AMO_ALU_ADD  = 4'd1;
    localparam logic [L2_AMO_ALU_OP_WIDTH-1:0] L2_AMO_ALU_AND  = 4'd2;
    localparam logic [L2_AMO_ALU_OP_WIDTH-1:0] L2_AMO_ALU_OR   = 4'd3;
    localparam logic [L2_AMO_ALU_OP_WIDTH-1:0] L2_AMO_ALU_XOR  = 4'd4;
    localparam logic [L2_AMO_ALU_OP_WIDTH-1:0] L2_AMO_ALU_MAX  = 4'd5;
    localparam logic [L2_AMO_ALU_OP_WIDTH-1:0] L2_AMO_ALU_MAXU = 4'd6;
    localparam logic [L2_AMO_ALU_OP_WIDTH-1:0] L2_AMO_ALU_MIN  = 4'd7;
    localparam logic [L2_AMO_ALU_OP_WIDTH-1:0] L2_AMO_ALU_MINU = 4'd8;
    localparam logic [L2_AMO_ALU_OP_WIDTH-1:0] L2_AMO_ALU_SWAP = 4'd9;

    localparam logic [MSG_DATA_SIZE_WIDTH-1:0] MSG_DATA_SIZE_0B  = 3'd0;
    localparam logic [MSG_DATA_SIZE_WIDTH-1:0] MSG_DATA_SIZE_1B  = 3'd1;
    localparam logic [MSG_DATA_SIZE_WIDTH-1:0] MSG_DATA_SIZE_2B  = 3'd2;
    localparam logic [MSG_DATA_SIZE_WIDTH-1:0] MSG_DATA_SIZE_4B  = 3'd3;
    localparam logic [MSG_DATA_SIZE_WIDTH-1:0] MSG_DATA_SIZE_8B  = 3'd4;
    localparam logic [MSG_DATA_SIZE_WIDTH-1:0] MSG_DATA_SIZE_16B = 3'd5;
    localparam logic [MSG_DATA_SIZE_WIDTH-1:0] MSG_DATA_SIZE_32B = 3'd6;
    localparam logic [MSG_DATA_SIZE_WIDTH-1:0] MSG_DATA_SIZE_64B = 3'd7;

    typedef enum logic [2:0] {
        L2_AMO_SEQ_IDLE  = 3'd0,
        L2_AMO_SEQ_RD    = 3'd1,
        L2_AMO_SEQ_RWAIT = 3'd2,
        L2_AMO_SEQ_EXEC  = 3'd3,
        L2_AMO_SEQ_WR    = 3'd4,
        L2_AMO_SEQ_RESP  = 3'd5
    } l2_amo_seq_state_e;

    // Operand width in bytes; 0 marks a size the ALU does not operate on.
    function automatic logic [3:0] amo_size_bytes(
        input logic [MSG_DATA_SIZE_WIDTH-1:0] size
    );
        logic [3:0] n;
        case (size)
            MSG_DATA_SIZE_1B: n = 4'd1;
            MSG_DATA_SIZE_2B: n = 4'd2;
            MSG_DATA_SIZE_4B: n = 4'd4;
            MSG_DATA_SIZE_8B: n = 4'd8;
            default:          n = 4'd0;
        endcase
        return n;
    endfunction

    // Low-order byte mask; a shift by 64 yields 0, so 8 bytes gives all ones.
    function automatic logic [63:0] amo_byte_mask(input logic [3:0] n);
        return (64'd1 << {n, 3'b000}) - 64'd1;
    endfunction

    // Reverse the low n bytes of v, leaving the result right-aligned.
    function automatic logic [63:0] amo_bswap(
        input logic [63:0] v,
        input logic [3:0]  n
    );
        logic [63:0] r;
        logic [5:0]  sh;
        for (int i = 0; i < 8; i++) begin
            r[8*i +: 8] = v[8*(7-i) +: 8];
        end
        sh = {3'(4'd8 - n), 3'b000};
        return r >> sh;
    endfunction

endpackage

// File: rtl/l2_amo_alu.sv
// Combinational AMO datapath: extracts the addressed operand from the line,
// applies the opcode and merges the result back into the memory line.
module l2_amo_alu
    import l2_amo_seq_pkg::*;
#(
    parameter bit SWAP_ENDIANESS = 1'b1
) (
    input  logic [L2_AMO_ALU_OP_WIDTH-1:0] op,
    input  logic [3:0]                     offset,
    input  logic [MSG_DATA_SIZE_WIDTH-1:0] size,
    input  logic [L2_DATA_DATA_WIDTH-1:0]  mem,
    input  logic [L2_DATA_DATA_WIDTH-1:0]  data,
    output logic [L2_DATA_DATA_WIDTH-1:0]  result
);

    logic [3:0]                    nbytes;
    logic [6:0]                    shamt;
    logic [63:0]                   mask;
    logic [63:0]                   msb;
    logic [63:0]                   mem_v;
    logic [63:0]                   opd_v;
    logic [63:0]                   a;
    logic [63:0]                   b;
    logic [63:0]                   res_v;
    logic [63:0]                   res_m;
    logic [63:0]                   res_o;
    logic [L2_DATA_DATA_WIDTH-1:0] lane;
    logic                          a_neg;
    logic                          b_neg;
    logic                          ult;
    logic                          slt;

    always_comb begin
        nbytes = amo_size_bytes(size);
        shamt  = {offset, 3'b000};
        mask   = amo_byte_mask(nbytes);
        msb    = mask ^ (mask >> 1);
        mem_v  = 64'(mem >> shamt) & mask;
        opd_v  = 64'(data >> shamt) & mask;

        // Arithmetic is done in CPU byte order.
        a = SWAP_ENDIANESS ? amo_bswap(mem_v, nbytes) : mem_v;
        b = SWAP_ENDIANESS ? amo_bswap(opd_v, nbytes) : opd_v;

        a_neg = |(a & msb);
        b_neg = |(b & msb);
        ult   = a < b;
        slt   = (a_neg != b_neg) ? a_neg : ult;

        case (op)
            L2_AMO_ALU_ADD:  res_v = a + b;
            L2_AMO_ALU_AND:  res_v = a & b;
            L2_AMO_ALU_OR:   res_v = a | b;
            L2_AMO_ALU_XOR:  res_v = a ^ b;
            L2_AMO_ALU_MAX:  res_v = slt ? b : a;
            L2_AMO_ALU_MAXU: res_v = ult ? b : a;
            L2_AMO_ALU_MIN:  res_v = slt ? a : b;
            L2_AMO_ALU_MINU: res_v = ult ? a : b;
            L2_AMO_ALU_SWAP: res_v = b;
            default:         res_v = a;
        endcase

        res_m = res_v & mask;
        res_o = SWAP_ENDIANESS ? amo_bswap(res_m, nbytes) : res_m;
        lane  = L2_DATA_DATA_WIDTH'(mask) << shamt;

        result = mem;
        if (nbytes != 4'd0) begin
            result = (mem & ~lane)
                   | (L2_DATA_DATA_WIDTH'(res_o) << shamt);
        end
    end

endmodule

// File: rtl/l2_amo_seq.sv
// Single-outstanding AMO sequencer: read line, run l2_amo_alu, write back,
// return the pre-operation line. Owns the data-array port while busy.
module l2_amo_seq
    import l2_amo_seq_pkg::*;
#(
    parameter bit          SWAP_ENDIANESS = 1'b1,
    parameter int unsigned RD_LAT         = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [L2_AMO_ALU_OP_WIDTH-1:0] req_op,
    input  logic [PHY_ADDR_WIDTH-1:0]      req_addr,
    input  logic [MSG_DATA_SIZE_WIDTH-1:0] req_size,
    input  logic [L2_DATA_DATA_WIDTH-1:0]  req_data,
    output logic                           dat_rd_valid,
    input  logic                           dat_rd_gnt,
    input  logic [L2_DATA_DATA_WIDTH-1:0]  dat_rdata,
    output logic                           dat_wr_valid,
    input  logic                           dat_wr_gnt,
    output logic [PHY_ADDR_WIDTH-1:0]      dat_addr,
    output logic [L2_DATA_DATA_WIDTH-1:0]  dat_wdata,
    output logic                           resp_valid,
    input  logic                           resp_ready,
    output logic [L2_DATA_DATA_WIDTH-1:0]  resp_data,
    output logic                           busy
);

    localparam logic [2:0] LAT = 3'(RD_LAT);

    l2_amo_seq_state_e state_q;
    l2_amo_seq_state_e state_n;

    logic [2:0]                     cnt_q;
    logic [2:0]                     cnt_n;
    logic [L2_AMO_ALU_OP_WIDTH-1:0] op_q;
    logic [PHY_ADDR_WIDTH-1:0]      addr_q;
    logic [MSG_DATA_SIZE_WIDTH-1:0] size_q;
    logic [L2_DATA_DATA_WIDTH-1:0]  data_q;
    logic [L2_DATA_DATA_WIDTH-1:0]  mem_q;
    logic [L2_DATA_DATA_WIDTH-1:0]  wdata_q;
    logic [L2_DATA_DATA_WIDTH-1:0]  alu_result;
    logic                           rd_valid_q;
    logic                           wr_valid_q;
    logic                           resp_valid_q;
    logic                           load;
    logic                           capture;
    logic                           exec;

    l2_amo_alu #(
        .SWAP_ENDIANESS(SWAP_ENDIANESS)
    ) u_alu (
        .op    (op_q),
        .offset(addr_q[3:0]),
        .size  (size_q),
        .mem   (mem_q),
        .data  (data_q),
        .result(alu_result)
    );

    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        load    = 1'b0;
        capture = 1'b0;
        exec    = 1'b0;
        case (state_q)
            L2_AMO_SEQ_IDLE: begin
                if (req_valid) begin
                    load    = 1'b1;
                    state_n = L2_AMO_SEQ_RD;
                end
            end
            L2_AMO_SEQ_RD: begin
                if (dat_rd_gnt) begin
                    cnt_n   = LAT;
                    state_n = L2_AMO_SEQ_RWAIT;
                end
            end
            L2_AMO_SEQ_RWAIT: begin
                // Read data is valid in the cycle the count reaches zero.
                cnt_n = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    capture = 1'b1;
                    state_n = L2_AMO_SEQ_EXEC;
                end
            end
            L2_AMO_SEQ_EXEC: begin
                exec    = 1'b1;
                state_n = (op_q == L2_AMO_ALU_NOP) ? L2_AMO_SEQ_RESP
                                                   : L2_AMO_SEQ_WR;
            end
            L2_AMO_SEQ_WR: begin
                if (dat_wr_gnt) begin
                    state_n = L2_AMO_SEQ_RESP;
                end
            end
            L2_AMO_SEQ_RESP: begin
                if (resp_ready) begin
                    state_n = L2_AMO_SEQ_IDLE;
                end
            end
            default: state_n = L2_AMO_SEQ_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= L2_AMO_SEQ_IDLE;
            cnt_q        <= '0;
            op_q         <= '0;
            addr_q       <= '0;
            size_q       <= '0;
            data_q       <= '0;
            mem_q        <= '0;
            wdata_q      <= '0;
            rd_valid_q   <= 1'b0;
            wr_valid_q   <= 1'b0;
            resp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_n;
            cnt_q        <= cnt_n;
            // Request strobes follow the next state so they stay registered.
            rd_valid_q   <= (state_n == L2_AMO_SEQ_RD);
            wr_valid_q   <= (state_n == L2_AMO_SEQ_WR);
            resp_valid_q <= (state_n == L2_AMO_SEQ_RESP);
            if (load) begin
                op_q   <= req_op;
                addr_q <= req_addr;
                size_q <= req_size;
                data_q <= req_data;
            end
            if (capture) begin
                mem_q <= dat_rdata;
            end
            if (exec) begin
                wdata_q <= alu_result;
            end
        end
    end

    assign req_ready    = (state_q == L2_AMO_SEQ_IDLE);
    assign busy         = (state_q != L2_AMO_SEQ_IDLE);
    assign dat_rd_valid = rd_valid_q;
    assign dat_wr_valid = wr_valid_q;
    assign dat_addr     = addr_q;
    assign dat_wdata    = wdata_q;
    assign resp_valid   = resp_valid_q;
    assign resp_data    = mem_q;

endmodule

// File: tb/tb_l2_amo_seq.sv
// Directed bench for l2_amo_seq: RD_LAT=2 and RD_LAT=1 instances,
// hand-computed lines and cycle positions checked with immediate assertions.
module tb_l2_amo_seq;
    import l2_amo_seq_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid;
    logic         req_valid1;
    logic [3:0]   req_op;
    logic [39:0]  req_addr;
    logic [2:0]   req_size;
    logic [127:0] req_data;
    logic         rd_gnt;
    logic         wr_gnt;
    logic         resp_ready;
    logic [127:0] rdata;
    logic [127:0] mem_line;
    logic [2:0]   lat_idx;
    logic [7:0]   gpipe = '0;

    logic         req_ready,  rd_valid,  wr_valid,  resp_valid,  busy;
    logic [39:0]  dat_addr;
    logic [127:0] wdata,  resp_data;
    logic         req_ready1, rd_valid1, wr_valid1, resp_valid1, busy1;
    logic [39:0]  dat_addr1;
    logic [127:0] wdata1, resp_data1;

    int vecs = 0;
    int errs = 0;
    int wr_cnt = 0;
    int resp_cnt = 0;

    always #5 clk = ~clk;

    l2_amo_seq #(.SWAP_ENDIANESS(1'b0), .RD_LAT(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_addr(req_addr),
        .req_size(req_size), .req_data(req_data),
        .dat_rd_valid(rd_valid), .dat_rd_gnt(rd_gnt), .dat_rdata(rdata),
        .dat_wr_valid(wr_valid), .dat_wr_gnt(wr_gnt),
        .dat_addr(dat_addr), .dat_wdata(wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .busy(busy)
    );

    l2_amo_seq #(.SWAP_ENDIANESS(1'b0), .RD_LAT(1)) dut1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid1), .req_ready(req_ready1),
        .req_op(req_op), .req_addr(req_addr),
        .req_size(req_size), .req_data(req_data),
        .dat_rd_valid(rd_valid1), .dat_rd_gnt(rd_gnt), .dat_rdata(rdata),
        .dat_wr_valid(wr_valid1), .dat_wr_gnt(wr_gnt),
        .dat_addr(dat_addr1), .dat_wdata(wdata1),
        .resp_valid(resp_valid1), .resp_ready(resp_ready),
        .resp_data(resp_data1), .busy(busy1)
    );

    // Array model: the line is driven only in the cycle the latency dictates.
    always @(posedge clk) begin
        gpipe <= {gpipe[6:0], (rd_valid | rd_valid1) & rd_gnt};
        if (wr_valid) wr_cnt <= wr_cnt + 1;
        if (resp_valid) resp_cnt <= resp_cnt + 1;
    end
    assign rdata = gpipe[lat_idx] ? mem_line : {4{32'hBADC0DE5}};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic issue(input bit sel, input logic [3:0] op,
                         input logic [39:0] a, input logic [2:0] sz,
                         input logic [127:0] d);
        chkb("req_ready_before_issue", sel ? req_ready1 : req_ready, 1'b1);
        req_op   = op;
        req_addr = a;
        req_size = sz;
        req_data = d;
        if (sel) req_valid1 = 1'b1;
        else     req_valid  = 1'b1;
        tick();
        req_valid  = 1'b0;
        req_valid1 = 1'b0;
    endtask

    task automatic wait_resp(input bit sel, output int t);
        t = 1;
        while (((sel ? resp_valid1 : resp_valid) == 1'b0) && t < 40) begin
            tick();
            t++;
        end
    endtask

    task automatic release_resp();
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t;
        int base_wr;
        int base_resp;

        rst        = 1'b1;
        req_valid  = 1'b0;
        req_valid1 = 1'b0;
        req_op     = '0;
        req_addr   = '0;
        req_size   = '0;
        req_data   = '0;
        rd_gnt     = 1'b1;
        wr_gnt     = 1'b1;
        resp_ready = 1'b0;
        mem_line   = '0;
        lat_idx    = 3'd1;
        tick();
        tick();
        rst = 1'b0;

        chkb("rst_req_ready", req_ready, 1'b1);
        chkb("rst_busy", busy, 1'b0);
        chkb("rst_rd_valid", rd_valid, 1'b0);
        chkb("rst_wr_valid", wr_valid, 1'b0);
        chkb("rst_resp_valid", resp_valid, 1'b0);
        chk("rst_resp_data", resp_data, '0);
        chk("rst_wdata", wdata, '0);
        chk("rst_addr", 128'(dat_addr), '0);
        chkb("rst_req_ready1", req_ready1, 1'b1);

        // ADD 8B at dword1, immediate grants
        mem_line = {64'h0000_0000_0000_0005, 64'hDEAD_BEEF_CAFE_F00D};
        base_wr  = wr_cnt;
        issue(0, L2_AMO_ALU_ADD, 40'h12_3456_7808, MSG_DATA_SIZE_8B,
              {64'h3, 64'h0});
        chkb("add_rd_valid_t1", rd_valid, 1'b1);
        wait_resp(0, t);
        chki("add_resp_cycle", t, 6);
        chk("add_resp_data", resp_data, mem_line);
        chk("add_wdata", wdata,
            {64'h0000_0000_0000_0008, 64'hDEAD_BEEF_CAFE_F00D});
        chk("add_addr", 128'(dat_addr), 128'(40'h12_3456_7808));
        chki("add_wr_cycles", wr_cnt - base_wr, 1);
        chkb("add_busy_resp", busy, 1'b1);
        release_resp();
        chkb("add_resp_drop", resp_valid, 1'b0);
        chkb("add_idle_ready", req_ready, 1'b1);

        // MAXU 4B, read grant 3 cycles late, write grant 2 cycles late
        mem_line = {64'h0123_4567_89AB_CDEF, 64'h7000_0000_5555_5555};
        rd_gnt   = 1'b0;
        wr_gnt   = 1'b0;
        issue(0, L2_AMO_ALU_MAXU, 40'h00_0000_1004, MSG_DATA_SIZE_4B,
              {64'hAAAA_AAAA_AAAA_AAAA, 64'h9000_0000_1234_5678});
        for (int i = 0; i < 3; i++) begin
            chkb("stall_rd_valid", rd_valid, 1'b1);
            chkb("stall_rd_no_wr", wr_valid, 1'b0);
            chk("stall_rd_addr", 128'(dat_addr), 128'(40'h00_0000_1004));
            tick();
        end
        chkb("stall_rd_valid_t4", rd_valid, 1'b1);
        rd_gnt = 1'b1;
        tick();
        rd_gnt = 1'b0;
        chkb("stall_rd_dropped", rd_valid, 1'b0);
        t = 5;
        while (!wr_valid && t < 40) begin
            tick();
            t++;
        end
        chki("stall_wr_cycle", t, 8);
        for (int i = 0; i < 2; i++) begin
            chkb("stall_wr_valid", wr_valid, 1'b1);
            chkb("stall_wr_no_rd", rd_valid, 1'b0);
            chk("stall_wr_data", wdata,
                {64'h0123_4567_89AB_CDEF, 64'h9000_0000_5555_5555});
            tick();
        end
        chkb("stall_wr_valid_t10", wr_valid, 1'b1);
        wr_gnt = 1'b1;
        tick();
        chkb("stall_resp_t11", resp_valid, 1'b1);
        chkb("stall_wr_dropped", wr_valid, 1'b0);
        chk("stall_resp_data", resp_data, mem_line);
        release_resp();
        rd_gnt = 1'b1;

        // NOP: pure atomic load, no write
        mem_line = {64'hFEDC_BA98_7654_3210, 64'h0F0F_0F0F_F0F0_F0F0};
        base_wr  = wr_cnt;
        issue(0, L2_AMO_ALU_NOP, 40'h00_0000_0020, MSG_DATA_SIZE_8B,
              {128{1'b1}});
        wait_resp(0, t);
        chki("nop_resp_cycle", t, 5);
        chk("nop_resp_data", resp_data, mem_line);
        release_resp();
        tick();
        chki("nop_no_write", wr_cnt - base_wr, 0);

        // XOR with response backpressure while a second request waits
        mem_line = {64'h1000_0000_0000_0001, 64'h00FF_00FF_00FF_00FF};
        issue(0, L2_AMO_ALU_XOR, 40'h00_0000_0040, MSG_DATA_SIZE_8B,
              {64'hFFFF_FFFF_FFFF_FFFF, 64'hFF00_FF00_FF00_FF00});
        req_op    = L2_AMO_ALU_ADD;
        req_addr  = 40'h00_0000_0048;
        req_size  = MSG_DATA_SIZE_8B;
        req_data  = {64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
        req_valid = 1'b1;
        wait_resp(0, t);
        chki("bp_resp_cycle", t, 6);
        chk("bp_xor_wdata", wdata,
            {64'h1000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF});
        for (int i = 0; i < 4; i++) begin
            chkb("bp_resp_held", resp_valid, 1'b1);
            chkb("bp_req_ready_low", req_ready, 1'b0);
            chk("bp_addr_held", 128'(dat_addr), 128'(40'h00_0000_0040));
            tick();
        end
        release_resp();
        chkb("bp_idle_ready", req_ready, 1'b1);
        chkb("bp_idle_busy", busy, 1'b0);
        chkb("bp_idle_resp", resp_valid, 1'b0);
        tick();
        req_valid = 1'b0;
        chkb("bp_second_busy", busy, 1'b1);
        chk("bp_second_addr", 128'(dat_addr), 128'(40'h00_0000_0048));
        wait_resp(0, t);
        chki("bp_second_cycle", t, 6);
        chk("bp_second_wdata", wdata,
            {64'h1000_0000_0000_0000, 64'h00FF_00FF_00FF_00FF});
        chk("bp_second_resp", resp_data, mem_line);
        release_resp();

        // Reset while waiting for read data
        mem_line  = {64'h5A5A_5A5A_5A5A_5A5A, 64'hA5A5_A5A5_A5A5_A5A5};
        base_wr   = wr_cnt;
        base_resp = resp_cnt;
        issue(0, L2_AMO_ALU_ADD, 40'h99_0000_0000, MSG_DATA_SIZE_8B,
              {64'h1, 64'h1});
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chkb("mrst_busy", busy, 1'b0);
        chkb("mrst_req_ready", req_ready, 1'b1);
        chkb("mrst_rd_valid", rd_valid, 1'b0);
        chk("mrst_addr", 128'(dat_addr), '0);
        for (int i = 0; i < 6; i++) tick();
        chki("mrst_no_write", wr_cnt - base_wr, 0);
        chki("mrst_no_resp", resp_cnt - base_resp, 0);
        chk("mrst_late_data_ignored", resp_data, '0);
        chk("mrst_wdata", wdata, '0);

        // Unrecognised opcode: line written back unchanged
        mem_line = {64'h1357_9BDF_2468_ACE0, 64'h0000_0000_0000_0042};
        base_wr  = wr_cnt;
        issue(0, 4'hF, 40'h00_0000_0010, MSG_DATA_SIZE_8B, {64'h1, 64'h1});
        wait_resp(0, t);
        chki("badop_resp_cycle", t, 6);
        chk("badop_wdata", wdata, mem_line);
        chki("badop_wrote", wr_cnt - base_wr, 1);
        release_resp();

        // RD_LAT=1 instance: SWAP 2B at byte offset 6
        lat_idx  = 3'd0;
        mem_line = {64'hCAFE_BABE_0000_1111, 64'h1122_3344_5566_7788};
        issue(1, L2_AMO_ALU_SWAP, 40'h80_0000_0006, MSG_DATA_SIZE_2B,
              {64'h5A5A_5A5A_5A5A_5A5A, 64'hBEEF_9999_9999_9999});
        wait_resp(1, t);
        chki("lat1_resp_cycle", t, 5);
        chk("lat1_resp_data", resp_data1, mem_line);
        chk("lat1_wdata", wdata1,
            {64'hCAFE_BABE_0000_1111, 64'hBEEF_3344_5566_7788});
        chk("lat1_addr", 128'(dat_addr1), 128'(40'h80_0000_0006));
        release_resp();
        chkb("lat1_idle", req_ready1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
